// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: controller states and
// default geometry.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 16;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register (PC slot never
// pending) with three combinational busy lookups.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int PC_IDX = DEPTH - 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_srst,
  input  rf_state_e       i_state,
  input  logic            i_pend_set,
  input  logic [AW-1:0]   i_pend_addr,
  input  logic            i_we4,
  input  logic [AW-1:0]   i_wa4,
  input  logic [AW-1:0]   i_ra [3],
  output logic            o_busy [3]
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pend
      if (gi == PC_IDX) begin : g_pc
        assign w_pend_next[gi] = 1'b0;
      end else begin : g_reg
        // A new load marking the same register wins over the retiring one.
        assign w_pend_next[gi] = (i_pend_set && (i_pend_addr == AW'(gi))) ||
                                 (r_pend[gi] && !(i_we4 && (i_wa4 == AW'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_srst || (i_state != RUN)) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  generate
    for (gi = 0; gi < 3; gi++) begin : g_busy
      // Hide the bit while the retiring load is being written through the bypass.
      assign o_busy[gi] = (i_state == RUN) && (i_ra[gi] != PC_A) &&
                          r_pend[i_ra[gi]] && !(i_we4 && (i_wa4 == i_ra[gi]));
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Two-write / three-read register file with PC read override, write bypass,
// pending-load scoreboard and a post-reset clear sequence.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int PC_IDX = DEPTH - 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  input  logic [WIDTH-1:0] pc,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3,
  output logic             ready
);

  localparam logic [AW-1:0] PC_A   = AW'(PC_IDX);
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

  rf_state_e        r_state;
  logic [AW-1:0]    r_clr_cnt;
  logic             r_ready;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    w_ra   [3];
  logic [WIDTH-1:0] w_rd   [3];
  logic             w_busy [3];
  logic             w_run;

  assign w_run = (r_state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + AW'(1);
          if (r_clr_cnt == LAST_A) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Contents are only ever zeroed by the clear walk; port B is applied last so
  // it wins a same-address collision with port A.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        if (r_clr_cnt != PC_A) r_mem[r_clr_cnt] <= '0;
      end else begin
        if (we3 && (wa3 != PC_A)) r_mem[wa3] <= wd3;
        if (we4 && (wa4 != PC_A)) r_mem[wa4] <= wd4;
      end
    end
  end

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;
  assign w_ra[2] = ra3;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd
      always_comb begin
        w_rd[gi] = r_mem[w_ra[gi]];
        if (w_ra[gi] == PC_A)                   w_rd[gi] = pc;
        else if (!w_run)                        w_rd[gi] = '0;
        else if (we4 && (wa4 == w_ra[gi]))      w_rd[gi] = wd4;
        else if (we3 && (wa3 == w_ra[gi]))      w_rd[gi] = wd3;
      end
    end
  endgenerate

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .PC_IDX (PC_IDX)
  ) u_scoreboard (
    .clk         (clk),
    .i_srst      (reset),
    .i_state     (r_state),
    .i_pend_set  (pend_set),
    .i_pend_addr (pend_addr),
    .i_we4       (we4),
    .i_wa4       (wa4),
    .i_ra        (w_ra),
    .o_busy      (w_busy)
  );

  assign rd1   = w_rd[0];
  assign rd2   = w_rd[1];
  assign rd3   = w_rd[2];
  assign busy1 = w_busy[0];
  assign busy2 = w_busy[1];
  assign busy3 = w_busy[2];
  assign ready = r_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (WIDTH=32, DEPTH=16).
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic        we3, we4, pend_set;
  logic [3:0]  wa3, wa4, ra1, ra2, ra3, pend_addr;
  logic [31:0] wd3, wd4, pc;
  logic [31:0] rd1, rd2, rd3;
  logic        busy1, busy2, busy3, ready;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp dut (
    .clk       (clk),
    .reset     (reset),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .we4       (we4),
    .wa4       (wa4),
    .wd4       (wd4),
    .ra1       (ra1),
    .ra2       (ra2),
    .ra3       (ra3),
    .pc        (pc),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .rd1       (rd1),
    .rd2       (rd2),
    .rd3       (rd3),
    .busy1     (busy1),
    .busy2     (busy2),
    .busy3     (busy3),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it, checks land 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; we3 = 0; we4 = 0; pend_set = 0;
    wa3 = 0; wa4 = 0; ra1 = 4'd3; ra2 = 0; ra3 = 0; pend_addr = 0;
    wd3 = 0; wd4 = 0; pc = 32'h100;

    // Power-up clear sequence
    $display("step: reset and clear");
    tick();
    settle();
    chk("reset_ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      settle();
      chk($sformatf("clr_ready_e%0d", i), {31'd0, ready}, (i == 16) ? 32'd1 : 32'd0);
      if (i == 8) chk("clr_rd1_zero", rd1, 32'd0);
    end
    chk("r3_after_clear", rd1, 32'd0);
    ra1 = 4'd15;
    settle();
    chk("pc_read", rd1, 32'h100);
    chk("pc_busy", {31'd0, busy1}, 32'd0);

    // Port A bypass then commit
    $display("step: we3 bypass r5");
    we3 = 1; wa3 = 4'd5; wd3 = 32'hDEADBEEF; ra1 = 4'd5;
    settle();
    chk("byp_a_comb", rd1, 32'hDEADBEEF);
    tick();
    we3 = 0;
    settle();
    chk("byp_a_commit", rd1, 32'hDEADBEEF);

    // Same-address dual write: port B wins
    $display("step: dual write r7");
    we3 = 1; wa3 = 4'd7; wd3 = 32'd1; we4 = 1; wa4 = 4'd7; wd4 = 32'd2; ra2 = 4'd7;
    settle();
    chk("dual_comb", rd2, 32'd2);
    tick();
    we3 = 0; we4 = 0;
    settle();
    chk("dual_commit", rd2, 32'd2);

    // Scoreboard set / port-A no-clear / port-B clear
    $display("step: scoreboard r9");
    pend_set = 1; pend_addr = 4'd9; ra1 = 4'd9;
    settle();
    chk("pend_not_yet", {31'd0, busy1}, 32'd0);
    tick();
    pend_set = 0;
    settle();
    chk("pend_set", {31'd0, busy1}, 32'd1);
    we3 = 1; wa3 = 4'd9; wd3 = 32'h33;
    tick();
    we3 = 0;
    settle();
    chk("pend_we3_keep", {31'd0, busy1}, 32'd1);
    chk("we3_r9_data", rd1, 32'h33);
    we4 = 1; wa4 = 4'd9; wd4 = 32'h55;
    settle();
    chk("pend_we4_comb", {31'd0, busy1}, 32'd0);
    chk("we4_r9_byp", rd1, 32'h55);
    tick();
    we4 = 0;
    settle();
    chk("pend_cleared", {31'd0, busy1}, 32'd0);
    chk("we4_r9_commit", rd1, 32'h55);

    // Set and retire on the same register in one cycle: set wins
    $display("step: set+retire r6");
    pend_set = 1; pend_addr = 4'd6; we4 = 1; wa4 = 4'd6; wd4 = 32'h66; ra3 = 4'd6;
    tick();
    pend_set = 0; we4 = 0;
    settle();
    chk("set_wins_busy", {31'd0, busy3}, 32'd1);
    chk("set_wins_data", rd3, 32'h66);

    // PC slot: never pending, writes ignored
    $display("step: pc slot");
    pend_set = 1; pend_addr = 4'd15; ra2 = 4'd15;
    we3 = 1; wa3 = 4'd15; wd3 = 32'h77; pc = 32'h200; ra1 = 4'd15;
    settle();
    chk("pc_wr_before", rd1, 32'h200);
    tick();
    pend_set = 0; we3 = 0;
    settle();
    chk("pc_wr_after", rd1, 32'h200);
    chk("pc_never_busy", {31'd0, busy2}, 32'd0);

    // Reset in RUN, then again mid-clear
    $display("step: reset restart");
    we4 = 1; wa4 = 4'd4; wd4 = 32'hA; ra1 = 4'd4;
    tick();
    we4 = 0;
    settle();
    chk("r4_written", rd1, 32'hA);
    reset = 1;
    tick();
    reset = 0;
    settle();
    chk("run_reset_ready", {31'd0, ready}, 32'd0);
    chk("run_reset_busy", {31'd0, busy3}, 32'd0);
    for (int i = 1; i <= 5; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    settle();
    chk("mid_reset_ready", {31'd0, ready}, 32'd0);
    ra2 = 4'd5;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 9) begin
        we3 = 1; wa3 = 4'd5; wd3 = 32'h99; pend_set = 1; pend_addr = 4'd5;
      end
      if (i == 15) begin
        we3 = 0; pend_set = 0;
      end
      settle();
      chk($sformatf("reclr_ready_e%0d", i), {31'd0, ready}, (i == 16) ? 32'd1 : 32'd0);
      if (i == 10) chk("clr_rd_gated", rd2, 32'd0);
    end
    chk("r4_cleared", rd1, 32'd0);
    chk("r5_clear_wr_ignored", rd2, 32'd0);
    chk("r5_clear_pend_ignored", {31'd0, busy2}, 32'd0);
    chk("r6_pend_dropped", {31'd0, busy3}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
